// File: rtl/mem_access.sv
// mem_access: memory stage of the 5-stage RISC-V pipeline.
//
// Takes the execute-to-memory pipeline outputs, performs loads and stores on a
// request/grant/response data bus (byte-lane formatting, sign/zero extension),
// and owns the memory-to-writeback pipeline register. Upstream stages are held
// through stallM while a bus access is outstanding.
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   RegWriteM, MemWriteM,  control bits from the E/M register
//   MemtoRegM, strCtrlM    (strCtrlM = funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU)
//   rdM, ALUoutM, r2M      destination, effective address / ALU result, store data
//   dmem_*                 data-memory bus
//   stallM                 hold F/D/E/M this cycle
//   misalignM, bus_errM    one-cycle pulses: misaligned access, timeout abort
//   RegWriteW, rdW,        registered writeback outputs
//   resultW
//   stateDbg               current FSM state (0 IDLE, 1 REQ, 2 WAIT)
//
// Bus handshake: dmem_req is a request that stays asserted, with addr/we/wdata/
// wstrb stable, until the cycle dmem_gnt is seen high; request and grant high in
// the same cycle is the transfer. For a read, the data returns later in exactly
// one cycle with dmem_rvalid high; rvalid is only accepted while in WAIT, never
// in the grant cycle and never in IDLE.

module mem_access #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        MemtoRegM,
   input  logic [2:0]  strCtrlM,
   input  logic [4:0]  rdM,
   input  logic [31:0] ALUoutM,
   input  logic [31:0] r2M,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        stallM,
   output logic        misalignM,
   output logic        bus_errM,
   output logic        RegWriteW,
   output logic [4:0]  rdW,
   output logic [31:0] resultW,
   output logic [1:0]  stateDbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

   state_t      state, nextState;
   logic [15:0] toCnt;
   logic        cntClr, cntInc;
   logic        wEn;
   logic        reqRaw, stallRaw, misalRaw, busErrRaw;
   logic        memop, isStore, misaligned;
   logic [31:0] storeData, loadData;
   logic [3:0]  storeStrb;
   logic [7:0]  ldByte;
   logic [15:0] ldHalf;

   assign memop   = MemWriteM | MemtoRegM;
   assign isStore = MemWriteM;

   // Halfwords need bit 0 clear, words need both low bits clear.
   always_comb begin
      misaligned = 1'b0;
      case (strCtrlM[1:0])
         2'b01:   misaligned = ALUoutM[0];
         2'b10:   misaligned = (ALUoutM[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
      misaligned = misaligned & memop;
   end

   // Store data is replicated across lanes so the strobes alone pick the bytes.
   always_comb begin
      storeData = r2M;
      storeStrb = 4'b1111;
      case (strCtrlM[1:0])
         2'b00: begin
            storeData = {4{r2M[7:0]}};
            storeStrb = 4'b0001 << ALUoutM[1:0];
         end
         2'b01: begin
            storeData = {2{r2M[15:0]}};
            storeStrb = 4'b0011 << ALUoutM[1:0];
         end
         default: begin
            storeData = r2M;
            storeStrb = 4'b1111;
         end
      endcase
   end

   // Load extraction; ALUoutM is held stable by the stall until rvalid.
   always_comb begin
      ldByte = dmem_rdata[7:0];
      case (ALUoutM[1:0])
         2'b00: ldByte = dmem_rdata[7:0];
         2'b01: ldByte = dmem_rdata[15:8];
         2'b10: ldByte = dmem_rdata[23:16];
         2'b11: ldByte = dmem_rdata[31:24];
      endcase
      ldHalf = ALUoutM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (strCtrlM)
         3'b000:  loadData = {{24{ldByte[7]}}, ldByte};
         3'b001:  loadData = {{16{ldHalf[15]}}, ldHalf};
         3'b100:  loadData = {24'd0, ldByte};
         3'b101:  loadData = {16'd0, ldHalf};
         default: loadData = dmem_rdata;
      endcase
   end

   // FSM state register and timeout counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         toCnt <= 16'd0;
      end else begin
         state <= nextState;
         if (cntClr)
            toCnt <= 16'd0;
         else if (cntInc)
            toCnt <= toCnt + 16'd1;
      end
   end

   // Next-state and handshake logic. wEn marks the cycle the instruction in M
   // retires into W; any other unstalled cycle writes a bubble.
   always_comb begin
      nextState = state;
      reqRaw    = 1'b0;
      stallRaw  = 1'b0;
      misalRaw  = 1'b0;
      busErrRaw = 1'b0;
      wEn       = 1'b0;
      cntClr    = 1'b0;
      cntInc    = 1'b0;
      case (state)
         IDLE: begin
            if (!memop) begin
               wEn = 1'b1;
            end else if (misaligned) begin
               misalRaw = 1'b1;
            end else begin
               reqRaw = 1'b1;
               if (dmem_gnt && isStore) begin
                  wEn = 1'b1;
               end else begin
                  stallRaw  = 1'b1;
                  cntClr    = 1'b1;
                  nextState = dmem_gnt ? WAIT : REQ;
               end
            end
         end
         REQ: begin
            if (toCnt == TIMEOUT_LIM) begin
               busErrRaw = 1'b1;
               nextState = IDLE;
            end else begin
               reqRaw = 1'b1;
               if (dmem_gnt && isStore) begin
                  wEn       = 1'b1;
                  nextState = IDLE;
               end else if (dmem_gnt) begin
                  stallRaw  = 1'b1;
                  cntClr    = 1'b1;
                  nextState = WAIT;
               end else begin
                  stallRaw = 1'b1;
                  cntInc   = 1'b1;
               end
            end
         end
         WAIT: begin
            if (dmem_rvalid) begin
               wEn       = 1'b1;
               nextState = IDLE;
            end else if (toCnt == TIMEOUT_LIM) begin
               busErrRaw = 1'b1;
               nextState = IDLE;
            end else begin
               stallRaw = 1'b1;
               cntInc   = 1'b1;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Reset forces the visible handshake low at once, even with a memop in M.
   assign dmem_req   = reqRaw & ~rst;
   assign stallM     = stallRaw & ~rst;
   assign misalignM  = misalRaw & ~rst;
   assign bus_errM   = busErrRaw & ~rst;
   assign dmem_we    = dmem_req & isStore;
   assign dmem_addr  = {ALUoutM[31:2], 2'b00};
   assign dmem_wdata = storeData;
   assign dmem_wstrb = dmem_we ? storeStrb : 4'b0000;
   assign stateDbg   = state;

   // Memory-to-writeback register; bubbles keep resultW unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWriteW <= 1'b0;
         rdW       <= 5'd0;
         resultW   <= 32'd0;
      end else if (wEn) begin
         RegWriteW <= RegWriteM;
         rdW       <= rdM;
         resultW   <= MemtoRegM ? loadData : ALUoutM;
      end else begin
         RegWriteW <= 1'b0;
         rdW       <= 5'd0;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vector bench for mem_access. Single-cycle operations
// come from a record table; multi-cycle loads, the bus timeout and reset during
// an outstanding read are hand-written sequences.

module tb_mem_access;

   logic        clk;
   logic        rst;
   logic        RegWriteM, MemWriteM, MemtoRegM;
   logic [2:0]  strCtrlM;
   logic [4:0]  rdM;
   logic [31:0] ALUoutM, r2M;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        stallM, misalignM, bus_errM;
   logic        RegWriteW;
   logic [4:0]  rdW;
   logic [31:0] resultW;
   logic [1:0]  stateDbg;

   mem_access #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
      .strCtrlM(strCtrlM), .rdM(rdM), .ALUoutM(ALUoutM), .r2M(r2M),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .stallM(stallM), .misalignM(misalignM), .bus_errM(bus_errM),
      .RegWriteW(RegWriteW), .rdW(rdW), .resultW(resultW), .stateDbg(stateDbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // scoreboard
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // drivers
   task automatic drive_op(input logic mw, input logic mr, input logic rw,
                           input logic [2:0] ctrl, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] r2);
      MemWriteM = mw;
      MemtoRegM = mr;
      RegWriteM = rw;
      strCtrlM  = ctrl;
      rdM       = rd;
      ALUoutM   = alu;
      r2M       = r2;
   endtask

   task automatic drive_nop();
      drive_op(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        mw, mr, rw;
      logic [2:0]  ctrl;
      logic [4:0]  rd;
      logic [31:0] alu, r2;
      logic        gnt;
      logic        e_req, e_we;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_wstrb;
      logic        e_stall, e_mis;
      logic        e_rw;
      logic [4:0]  e_rd;
      logic [31:0] e_res;
   } vec_t;

   vec_t vecs[10];
   int   err_pulses;

   initial begin
      // mw mr rw ctrl rd alu r2 gnt | req we addr wdata wstrb stall mis | rw rd res
      vecs[0] = '{1'b0,1'b0,1'b1,3'b000,5'd5, 32'h0000_1234,32'h0,1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0, 1'b1,5'd5, 32'h0000_1234};
      vecs[1] = '{1'b1,1'b0,1'b0,3'b000,5'd0, 32'h0000_0103,32'hAABB_CCDD,1'b1, 1'b1,1'b1,32'h100,32'hDDDD_DDDD,4'b1000,1'b0,1'b0, 1'b0,5'd0, 32'h0000_0103};
      vecs[2] = '{1'b0,1'b1,1'b1,3'b010,5'd9, 32'h0000_0301,32'h0,1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b1, 1'b0,5'd0, 32'h0000_0103};
      vecs[3] = '{1'b1,1'b0,1'b0,3'b001,5'd0, 32'h0000_0302,32'h0000_BEEF,1'b1, 1'b1,1'b1,32'h300,32'hBEEF_BEEF,4'b1100,1'b0,1'b0, 1'b0,5'd0, 32'h0000_0302};
      vecs[4] = '{1'b1,1'b0,1'b0,3'b010,5'd0, 32'h0000_0404,32'h1234_5678,1'b1, 1'b1,1'b1,32'h404,32'h1234_5678,4'b1111,1'b0,1'b0, 1'b0,5'd0, 32'h0000_0404};
      vecs[5] = '{1'b1,1'b0,1'b0,3'b001,5'd0, 32'h0000_0501,32'h0000_1111,1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b1, 1'b0,5'd0, 32'h0000_0404};
      vecs[6] = '{1'b0,1'b0,1'b1,3'b000,5'd31,32'hFFFF_FFFF,32'h0,1'b1, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0, 1'b1,5'd31,32'hFFFF_FFFF};
      vecs[7] = '{1'b1,1'b0,1'b0,3'b000,5'd0, 32'h0000_0600,32'h0000_00A5,1'b1, 1'b1,1'b1,32'h600,32'hA5A5_A5A5,4'b0001,1'b0,1'b0, 1'b0,5'd0, 32'h0000_0600};
      vecs[8] = '{1'b0,1'b1,1'b1,3'b101,5'd2, 32'h0000_0703,32'h0,1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b1, 1'b0,5'd0, 32'h0000_0600};
      vecs[9] = '{1'b1,1'b0,1'b0,3'b000,5'd0, 32'h0000_0202,32'h0000_007E,1'b1, 1'b1,1'b1,32'h200,32'h7E7E_7E7E,4'b0100,1'b0,1'b0, 1'b0,5'd0, 32'h0000_0202};

      // reset, with a load presented so the gating of dmem_req is exercised
      rst         = 1'b1;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'd0;
      drive_op(1'b0, 1'b1, 1'b1, 3'b010, 5'd1, 32'h40, 32'd0);
      #3;
      check("rst_req", dmem_req, 1'b0);
      check("rst_stall", stallM, 1'b0);
      check("rst_misal", misalignM, 1'b0);
      check("rst_buserr", bus_errM, 1'b0);
      check("rst_rw", RegWriteW, 1'b0);
      check("rst_rd", rdW, 5'd0);
      check("rst_res", resultW, 32'd0);
      check("rst_state", stateDbg, 2'd0);
      next_cycle();
      check("rst_hold_req", dmem_req, 1'b0);
      check("rst_hold_res", resultW, 32'd0);
      drive_nop();
      rst = 1'b0;

      // table: single-cycle operations
      for (int i = 0; i < 10; i++) begin
         drive_op(vecs[i].mw, vecs[i].mr, vecs[i].rw, vecs[i].ctrl, vecs[i].rd,
                  vecs[i].alu, vecs[i].r2);
         dmem_gnt = vecs[i].gnt;
         #4;
         check($sformatf("v%0d_req", i), dmem_req, vecs[i].e_req);
         check($sformatf("v%0d_stall", i), stallM, vecs[i].e_stall);
         check($sformatf("v%0d_misal", i), misalignM, vecs[i].e_mis);
         if (vecs[i].e_req) begin
            check($sformatf("v%0d_we", i), dmem_we, vecs[i].e_we);
            check($sformatf("v%0d_addr", i), dmem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
            check($sformatf("v%0d_wstrb", i), dmem_wstrb, vecs[i].e_wstrb);
         end
         next_cycle();
         check($sformatf("v%0d_rw", i), RegWriteW, vecs[i].e_rw);
         check($sformatf("v%0d_rd", i), rdW, vecs[i].e_rd);
         check($sformatf("v%0d_res", i), resultW, vecs[i].e_res);
      end
      drive_nop();

      // LB then LBU at 0x202: grant on the third request cycle, rvalid next
      for (int k = 0; k < 2; k++) begin
         drive_op(1'b0, 1'b1, 1'b1, (k == 0) ? 3'b000 : 3'b100, 5'd10, 32'h202, 32'd0);
         dmem_rdata = 32'h0080_0000;
         exp_q.push_back((k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
         for (int c = 0; c < 4; c++) begin
            dmem_gnt    = (c == 2);
            dmem_rvalid = (c == 3);
            #4;
            check($sformatf("ld%0d_c%0d_req", k, c), dmem_req, (c < 3));
            check($sformatf("ld%0d_c%0d_stall", k, c), stallM, (c < 3));
            if (c == 0)
               check($sformatf("ld%0d_we", k), dmem_we, 1'b0);
            next_cycle();
            if (c < 3)
               check($sformatf("ld%0d_c%0d_bubble", k, c), RegWriteW, 1'b0);
         end
         drive_nop();
         check($sformatf("ld%0d_rw", k), RegWriteW, 1'b1);
         check($sformatf("ld%0d_rd", k), rdW, 5'd10);
         check($sformatf("ld%0d_res", k), resultW, exp_q.pop_front());
      end

      // bus timeout: load never granted, abort after four REQ cycles
      drive_op(1'b0, 1'b1, 1'b1, 3'b010, 5'd3, 32'h800, 32'd0);
      err_pulses = 0;
      for (int c = 0; c < 6; c++) begin
         #4;
         check($sformatf("to_c%0d_req", c), dmem_req, (c < 5));
         check($sformatf("to_c%0d_stall", c), stallM, (c < 5));
         check($sformatf("to_c%0d_err", c), bus_errM, (c == 5));
         check($sformatf("to_c%0d_state", c), stateDbg, (c == 0) ? 2'd0 : 2'd1);
         if (bus_errM) err_pulses++;
         next_cycle();
         check($sformatf("to_c%0d_rw", c), RegWriteW, 1'b0);
      end
      drive_nop();
      check("to_state_idle", stateDbg, 2'd0);
      #4;
      if (bus_errM) err_pulses++;
      check("to_pulses", err_pulses, 1);
      next_cycle();

      // reset while a read is outstanding in WAIT
      drive_op(1'b0, 1'b0, 1'b1, 3'b000, 5'd4, 32'h0000_CAFE, 32'd0);
      next_cycle();
      check("pre_res", resultW, 32'h0000_CAFE);
      drive_op(1'b0, 1'b1, 1'b1, 3'b010, 5'd12, 32'h900, 32'd0);
      dmem_gnt = 1'b1;
      #4;
      check("rw_gnt_stall", stallM, 1'b1);
      next_cycle();
      dmem_gnt = 1'b0;
      #1;
      check("rw_wait_state", stateDbg, 2'd2);
      check("rw_wait_stall", stallM, 1'b1);
      check("rw_wait_res", resultW, 32'h0000_CAFE);
      rst = 1'b1;
      #1;
      check("rw_rst_req", dmem_req, 1'b0);
      check("rw_rst_stall", stallM, 1'b0);
      check("rw_rst_rw", RegWriteW, 1'b0);
      check("rw_rst_rd", rdW, 5'd0);
      check("rw_rst_res", resultW, 32'd0);
      check("rw_rst_state", stateDbg, 2'd0);
      drive_nop();
      next_cycle();
      rst         = 1'b0;
      dmem_rdata  = 32'h1234_5678;
      dmem_rvalid = 1'b1;
      #4;
      check("stale_req", dmem_req, 1'b0);
      check("stale_stall", stallM, 1'b0);
      next_cycle();
      dmem_rvalid = 1'b0;
      check("stale_res", resultW, 32'd0);
      check("stale_rw", RegWriteW, 1'b0);

      check("sb_empty", exp_q.size(), 0);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the 5-stage RISC-V pipeline. It consumes the execute-to-memory pipeline outputs: ALUoutM, r2M, rdM, strCtrlM, RegWriteM, MemWriteM and MemtoRegM.
- It performs loads and stores over a request/grant/response data-memory bus, formatting byte lanes and sign/zero extension.
- It owns the memory-to-writeback pipeline register that produces resultW, RegWriteW and rdW for writeback and for forwarding.
- It stalls upstream stages while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for dmem_gnt or dmem_rvalid before aborting with bus error. Range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- RegWriteM  in  1  instruction writes rd
- MemWriteM  in  1  store
- MemtoRegM  in  1  load
- strCtrlM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rdM  in  5  destination register
- ALUoutM  in  32  effective address, or ALU result for non-memory ops
- r2M  in  32  store data
- dmem_req  out  1  bus request
- dmem_we  out  1  1=write
- dmem_addr  out  32  word-aligned address ({ALUoutM[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes (0 for reads)
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- stallM  out  1  hold F/D/E/M stages this cycle
- misalignM  out  1  one-cycle pulse on misaligned access
- bus_errM  out  1  one-cycle pulse on timeout abort
- RegWriteW  out  1  registered
- rdW  out  5  registered
- resultW  out  32  registered writeback value

Behaviour:
- Reset: FSM=IDLE, timeout counter=0. RegWriteW=0, rdW=0, resultW=0. dmem_req=0, stallM=0, misalignM=0, bus_errM=0.
- memop = MemWriteM|MemtoRegM.
- Misaligned when:
  - H/HU/SH with ALUoutM[0]=1, or
  - W/SW with ALUoutM[1:0]!=0.
- Misaligned access: no request; misalignM=1 for one cycle; stallM=0; W captures a bubble (RegWriteW=0).
- Store formatting:
  - SB: wdata={4{r2M[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{r2M[15:0]}}, wstrb=0011<<addr[1:0].
  - SW: wdata=r2M, wstrb=1111.
- Load extraction: select byte/half by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU).
- FSM states IDLE, REQ, WAIT:
  - IDLE, aligned memop:
    - dmem_req=1 combinationally.
    - Store with gnt: complete this cycle, stallM=0, stay IDLE.
    - Load with gnt: stallM=1, go to WAIT.
    - No gnt: stallM=1, go to REQ.
  - REQ: dmem_req held with addr/we/wdata/wstrb stable.
    - On gnt, store: complete, stallM=0, go to IDLE.
    - On gnt, load: stallM=1, go to WAIT.
  - WAIT: dmem_req=0, stallM=1 until dmem_rvalid.
    - On rvalid: stallM=0, resultW captures extracted data, go to IDLE.
  - Load takes ≥1 stall cycle; store with immediate grant takes 0.
  - rvalid in the same cycle as gnt is not supported; rvalid is only sampled in WAIT.
- W register: updated every cycle stallM=0.
  - RegWriteW=RegWriteM, rdW=rdM.
  - resultW = load data if MemtoRegM, else ALUoutM.
  - While stallM=1, W captures a bubble (RegWriteW=0, rdW=0, resultW unchanged).
- Timeout:
  - Counter clears on entry to REQ/WAIT and increments each cycle there.
  - When counter reaches TIMEOUT_CYCLES without gnt/rvalid: drop req, pulse bus_errM, stallM=0, W bubble, go to IDLE.
- dmem_rvalid or dmem_gnt in IDLE with no request: ignored.
- Reset mid-access: FSM returns to IDLE immediately, dmem_req drops asynchronously, and a later stale rvalid is ignored.
- Non-memory instruction: no request, stallM=0, passes ALUoutM to resultW next cycle.

Test Plan:
- ALU passthrough: RegWriteM=1, rdM=5, ALUoutM=0x1234 -> next cycle RegWriteW=1, rdW=5, resultW=0x1234; dmem_req never asserted.
- SB, immediate grant: ALUoutM=0x103, r2M=0xAABBCCDD, gnt=1 -> same cycle wstrb=1000, wdata=0xDDDDDDDD, addr=0x100, stallM=0.
- LB with 2-cycle grant delay then rvalid: addr 0x202, rdata=0x00800000 -> stallM high until rvalid; resultW=0xFFFFFF80. Repeat as LBU -> resultW=0x00000080.
- LW misaligned: ALUoutM=0x301 -> misalignM pulse, no dmem_req, RegWriteW=0 next cycle. SH at 0x302 is aligned and proceeds with wstrb=1100.
- Timeout with TIMEOUT_CYCLES=4: load, gnt never asserted -> bus_errM pulses once after 4 REQ cycles, stallM drops, RegWriteW=0.
- rst asserted while in WAIT -> dmem_req=0, stallM=0, all W outputs 0 immediately; rvalid pulsed after reset release leaves resultW=0.
